// File: rtl/tile_pixel_serializer_pkg.sv
// Shared types and helpers for the tile pixel serializer: the tile-row layout
// and the planar ROM word unpacker.
package tile_pixel_serializer_pkg;
    localparam int PIX_BITS = 4;
    localparam int ATTR_W   = 8;
    localparam int PLANE_W  = 8;
    localparam int ROM_W    = PIX_BITS * PLANE_W;
    localparam int ROW_W    = ATTR_W + PLANE_W * PIX_BITS;

    localparam int LAY_FIX = 0;
    localparam int LAY_A   = 1;
    localparam int LAY_B   = 2;

    typedef struct packed {
        logic [ATTR_W-1:0]                attr;
        logic [PLANE_W-1:0][PIX_BITS-1:0] pix;
    } tile_row_t;

    // Plane k holds pixel p at bit k*8+(7-p); hflip mirrors p.
    function automatic tile_row_t unpack_row(input logic [ROM_W-1:0] d,
                                             input logic [ATTR_W-1:0] a,
                                             input logic hf);
        tile_row_t r;
        r.attr = a;
        for (int p = 0; p < PLANE_W; p++)
            for (int k = 0; k < PIX_BITS; k++)
                r.pix[p][k] = d[k*PLANE_W + (hf ? p : PLANE_W-1-p)];
        return r;
    endfunction
endpackage

// File: rtl/tile_pixel_serializer_layer.sv
// One layer's staging/front/back tile pipeline, underrun tracking and
// fine-scrolled pixel select.
module tile_layer_pipe
    import tile_pixel_serializer_pkg::*;
(
    input  logic                clk_24M,
    input  logic                nRES,
    input  logic                bnd,
    input  logic                ld,
    input  logic                clr_err,
    input  logic [ROW_W-1:0]    row_in,
    input  logic [2:0]          z,
    input  logic [2:0]          px_nx,
    output logic [PIX_BITS-1:0] sel_pix,
    output logic [ATTR_W-1:0]   sel_attr,
    output logic                underrun
);
    tile_row_t row, stg, front, back, front_nx, back_nx;
    logic      stg_v;
    logic [3:0] idx;

    assign row = tile_row_t'(row_in);

    // Select reads the post-boundary buffers so px==0 already shows the new tile.
    always_comb begin
        back_nx  = back;
        front_nx = front;
        if (bnd) begin
            back_nx = front;
            if (ld)         front_nx = row;
            else if (stg_v) front_nx = stg;
            else            front_nx = '0;
        end
        idx = {1'b0, px_nx} + {1'b0, z};
        if (idx[3]) begin
            sel_pix  = front_nx.pix[idx[2:0]];
            sel_attr = front_nx.attr;
        end else begin
            sel_pix  = back_nx.pix[idx[2:0]];
            sel_attr = back_nx.attr;
        end
    end

    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            stg      <= '0;
            front    <= '0;
            back     <= '0;
            stg_v    <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (ld) stg <= row;
            if (bnd)     stg_v <= 1'b0;
            else if (ld) stg_v <= 1'b1;
            front <= front_nx;
            back  <= back_nx;
            if (bnd && !stg_v && !ld) underrun <= 1'b1;
            else if (clr_err)         underrun <= 1'b0;
        end
    end
endmodule

// File: rtl/tile_pixel_serializer.sv
// Serialises GFX ROM words into fix/A/B pixel streams at pixel rate, with
// per-layer fine scroll, blanking and sticky underrun reporting.
module tile_pixel_serializer
    import tile_pixel_serializer_pkg::*;
(
    input  logic                clk_24M,
    input  logic                nRES,
    input  logic                pix_ce,
    input  logic [2:0]          ld,
    input  logic [31:0]         rom_d,
    input  logic [ATTR_W-1:0]   col,
    input  logic                hflip,
    input  logic [2:0]          za,
    input  logic [2:0]          zb,
    input  logic                blank,
    input  logic                clr_err,
    output logic [PIX_BITS-1:0] pix_fix,
    output logic [PIX_BITS-1:0] pix_a,
    output logic [PIX_BITS-1:0] pix_b,
    output logic [ATTR_W-1:0]   attr_fix,
    output logic [ATTR_W-1:0]   attr_a,
    output logic [ATTR_W-1:0]   attr_b,
    output logic [2:0]          opq,
    output logic [2:0]          px,
    output logic [2:0]          underrun
);
    logic [2:0]                     px_nx;
    logic                           bnd;
    logic [ROW_W-1:0]               row;
    logic [2:0][2:0]                z_l;
    logic [2:0][PIX_BITS-1:0]       sel_pix, pix_r;
    logic [2:0][ATTR_W-1:0]         sel_attr, attr_r;

    assign px_nx = px + 3'd1;
    assign bnd   = pix_ce && (px == 3'd7);
    assign row   = unpack_row(rom_d, col, hflip);
    assign z_l   = {zb, za, 3'd0};

    genvar g;
    for (g = 0; g < 3; g++) begin : g_lay
        tile_layer_pipe u_pipe (
            .clk_24M  (clk_24M),
            .nRES     (nRES),
            .bnd      (bnd),
            .ld       (ld[g]),
            .clr_err  (clr_err),
            .row_in   (row),
            .z        (z_l[g]),
            .px_nx    (px_nx),
            .sel_pix  (sel_pix[g]),
            .sel_attr (sel_attr[g]),
            .underrun (underrun[g])
        );
    end

    // Blank only masks the outputs; px and the buffers keep advancing.
    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            px     <= '0;
            pix_r  <= '0;
            attr_r <= '0;
            opq    <= '0;
        end else if (pix_ce) begin
            px <= px_nx;
            for (int n = 0; n < 3; n++) begin
                pix_r[n]  <= blank ? '0 : sel_pix[n];
                attr_r[n] <= blank ? '0 : sel_attr[n];
                opq[n]    <= !blank && (|sel_pix[n]);
            end
        end
    end

    assign pix_fix  = pix_r[LAY_FIX];
    assign pix_a    = pix_r[LAY_A];
    assign pix_b    = pix_r[LAY_B];
    assign attr_fix = attr_r[LAY_FIX];
    assign attr_a   = attr_r[LAY_A];
    assign attr_b   = attr_r[LAY_B];
endmodule

// File: tb/tb_tile_pixel_serializer.sv
// Bench for tile_pixel_serializer: directed scenarios plus random traffic,
// checked every clock against an array-based model of the tile pipeline.
module tb_tile_pixel_serializer;
    logic        clk_24M, nRES, pix_ce, hflip, blank, clr_err;
    logic [2:0]  ld, za, zb;
    logic [31:0] rom_d;
    logic [7:0]  col;
    logic [3:0]  pix_fix, pix_a, pix_b;
    logic [7:0]  attr_fix, attr_a, attr_b;
    logic [2:0]  opq, px, underrun;

    int checks = 0, failures = 0;
    bit chk_en = 0;

    // model state
    int m_px;
    int st[3][8], fr[3][8], bk[3][8];
    int st_a[3], fr_a[3], bk_a[3];
    bit stv[3], ur[3];
    int e_pix[3], e_attr[3];

    tile_pixel_serializer dut (
        .clk_24M(clk_24M), .nRES(nRES), .pix_ce(pix_ce), .ld(ld), .rom_d(rom_d),
        .col(col), .hflip(hflip), .za(za), .zb(zb), .blank(blank), .clr_err(clr_err),
        .pix_fix(pix_fix), .pix_a(pix_a), .pix_b(pix_b),
        .attr_fix(attr_fix), .attr_a(attr_a), .attr_b(attr_b),
        .opq(opq), .px(px), .underrun(underrun)
    );

    initial begin
        clk_24M = 0;
        forever #5 clk_24M = ~clk_24M;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int unpk(input logic [31:0] d, input bit hf, input int p);
        int v = 0;
        for (int k = 0; k < 4; k++)
            if (d[k*8 + (hf ? p : 7-p)]) v += (1 << k);
        return v;
    endfunction

    // Next-state of the model for the inputs currently applied.
    task automatic model_step();
        int z[3];
        bit nu[3];
        bit b;
        int i;
        if (!nRES) begin
            m_px = 0;
            for (int n = 0; n < 3; n++) begin
                for (int p = 0; p < 8; p++) begin st[n][p] = 0; fr[n][p] = 0; bk[n][p] = 0; end
                st_a[n] = 0; fr_a[n] = 0; bk_a[n] = 0; stv[n] = 0; ur[n] = 0;
                e_pix[n] = 0; e_attr[n] = 0;
            end
            return;
        end
        z[0] = 0; z[1] = int'(za); z[2] = int'(zb);
        b = pix_ce && (m_px == 7);
        if (pix_ce) m_px = (m_px + 1) % 8;
        for (int n = 0; n < 3; n++) begin
            nu[n] = 0;
            if (b) begin
                for (int p = 0; p < 8; p++) bk[n][p] = fr[n][p];
                bk_a[n] = fr_a[n];
                for (int p = 0; p < 8; p++)
                    fr[n][p] = ld[n] ? unpk(rom_d, hflip, p) : (stv[n] ? st[n][p] : 0);
                fr_a[n] = ld[n] ? int'(col) : (stv[n] ? st_a[n] : 0);
                nu[n] = !stv[n] && !ld[n];
                stv[n] = 0;
            end else if (ld[n]) begin
                for (int p = 0; p < 8; p++) st[n][p] = unpk(rom_d, hflip, p);
                st_a[n] = int'(col);
                stv[n] = 1;
            end
            if (pix_ce) begin
                i = m_px + z[n];
                e_pix[n]  = blank ? 0 : (i < 8 ? bk[n][i] : fr[n][i-8]);
                e_attr[n] = blank ? 0 : (i < 8 ? bk_a[n] : fr_a[n]);
            end
            if (nu[n]) ur[n] = 1;
            else if (clr_err) ur[n] = 0;
        end
    endtask

    always @(posedge clk_24M) begin
        #1;
        if (chk_en) begin
            check("pix_fix", pix_fix, e_pix[0]);
            check("pix_a", pix_a, e_pix[1]);
            check("pix_b", pix_b, e_pix[2]);
            check("attr_fix", attr_fix, e_attr[0]);
            check("attr_a", attr_a, e_attr[1]);
            check("attr_b", attr_b, e_attr[2]);
            check("opq", opq, {e_pix[2] != 0, e_pix[1] != 0, e_pix[0] != 0});
            check("px", px, m_px);
            check("underrun", underrun, {ur[2], ur[1], ur[0]});
        end
    end

    task automatic tick();
        model_step();
        @(posedge clk_24M);
        #2;
    endtask

    task automatic pixel(input logic [2:0] ld_ce, input logic [2:0] ld_mid);
        pix_ce = 1; ld = ld_ce;  tick();
        pix_ce = 0; ld = ld_mid; tick();
        ld = 0; tick(); tick();
    endtask

    // One load per tile period, issued just after px becomes 2.
    task automatic pixel_ld(input logic [2:0] ldm);
        pixel(3'b000, (m_px == 1) ? ldm : 3'b000);
    endtask

    task automatic tile(input logic [2:0] ldm);
        for (int q = 0; q < 8; q++) pixel_ld(ldm);
    endtask

    task automatic align();
        for (int q = 0; q < 8 && m_px != 0; q++) pixel_ld(3'b111);
    endtask

    initial begin
        nRES = 1; pix_ce = 0; ld = 0; rom_d = 0; col = 0; hflip = 0;
        za = 0; zb = 0; blank = 0; clr_err = 0;
        model_step();
        #3 nRES = 0;
        model_step();
        #1;
        check("rst_px", px, 0);
        check("rst_pix_fix", pix_fix, 0);
        check("rst_underrun", underrun, 0);
        chk_en = 1;
        for (int c = 0; c < 10; c++) begin pix_ce = c[0]; tick(); end
        pix_ce = 0;
        nRES = 1;
        tick();

        // unpack: all-ones plane 0
        rom_d = 32'h000000FF; col = 8'h11;
        tile(3'b111); tile(3'b111);
        check("ff_pix_fix", pix_fix, 1);
        check("ff_opq0", opq[0], 1);
        rom_d = 32'h00000080; col = 8'h22;
        tile(3'b111); tile(3'b111);
        check("x80_px0", pix_fix, 1);
        check("x80_attr", attr_fix, 8'h22);
        pixel_ld(3'b111);
        check("x80_px1", pix_fix, 0);
        for (int q = 0; q < 7; q++) pixel_ld(3'b111);
        hflip = 1;
        tile(3'b111); tile(3'b111);
        check("hf_px0", pix_fix, 0);
        for (int q = 0; q < 7; q++) pixel_ld(3'b111);
        check("hf_px7", pix_fix, 1);
        pixel_ld(3'b111);
        hflip = 0;

        // fine scroll: alternating all-3 / all-5 tiles, za=3
        za = 3;
        for (int j = 0; j < 4; j++) begin
            rom_d = j[0] ? 32'h00FF00FF : 32'h0000FFFF;
            col   = j[0] ? 8'hA1 : 8'hA0;
            tile(3'b111);
        end
        check("fs_px0", pix_a, 3);
        rom_d = 32'h0000FFFF; col = 8'hA0;
        for (int q = 1; q < 8; q++) begin
            pixel_ld(3'b111);
            if (m_px == 4) begin check("fs_px4", pix_a, 3); check("fs_attr4", attr_a, 8'hA0); end
            if (m_px == 5) begin check("fs_px5", pix_a, 5); check("fs_attr5", attr_a, 8'hA1); end
        end
        za = 0;
        align();

        // coincident load on layer A at the boundary
        for (int q = 0; q < 7; q++) pixel_ld(3'b101);
        rom_d = 32'h00FF00FF; col = 8'hC5;
        pixel(3'b010, 3'b000);
        check("coin_ur", underrun, 3'b000);
        tile(3'b101);
        check("coin_pix_a", pix_a, 5);
        check("coin_attr_a", attr_a, 8'hC5);
        check("coin_stg_empty", underrun, 3'b010);
        clr_err = 1; tick(); clr_err = 0;
        check("clr_ur", underrun, 3'b000);

        // underrun on B with clr_err coincident
        for (int q = 0; q < 7; q++) pixel_ld(3'b011);
        clr_err = 1; pix_ce = 1; tick();
        clr_err = 0; pix_ce = 0; tick(); tick(); tick();
        check("ur_b_wins", underrun, 3'b100);
        tile(3'b111);
        check("ur_pix_b", pix_b, 0);
        check("ur_opq_b", opq[2], 0);

        // blank four pixels mid-tile
        pixel_ld(3'b111); pixel_ld(3'b111);
        blank = 1;
        for (int q = 0; q < 4; q++) pixel_ld(3'b111);
        check("blank_pix", pix_fix, 0);
        check("blank_opq", opq, 0);
        check("blank_px", px, 6);
        blank = 0;
        pixel_ld(3'b111);
        check("unblank_pix", pix_fix, 5);
        pixel_ld(3'b111);

        // random traffic with a mid-line reset
        for (int c = 0; c < 3000; c++) begin
            pix_ce  = ($urandom % 4) == 0;
            ld      = (($urandom % 6) == 0) ? 3'($urandom) : 3'b000;
            rom_d   = $urandom;
            col     = 8'($urandom);
            hflip   = 1'($urandom);
            za      = 3'($urandom);
            zb      = 3'($urandom);
            blank   = ($urandom % 8) == 0;
            clr_err = ($urandom % 16) == 0;
            if (c == 1500) begin
                nRES = 0;
                #1;
                check("mid_rst_px", px, 0);
                check("mid_rst_pix", {pix_fix, pix_a, pix_b}, 0);
                tick(); tick();
                nRES = 1;
            end
            tick();
        end

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tile_pixel_serializer.md
Name: tile_pixel_serializer

Overview:
- Pixel-side counterpart to the tilemap address generator.
- Consumes the per-character GFX ROM words, the COL attribute bytes and the layer A/B fine-scroll values (ZA/ZB) that the address generator produces.
- Serialises them into three parallel pixel streams (fix, A, B) at pixel rate.
- Sits between GFX ROM data and the priority/palette mixer.

Parameters:
- PIX_BITS, 4, bits per pixel (planes per ROM word).
- ATTR_W, 8, attribute (COL) width latched per tile.

Ports:
- clk_24M  in  1  master clock.
- nRES  in  1  asynchronous active-low reset.
- pix_ce  in  1  pixel clock enable, 1 pulse per pixel (6 MHz nominal).
- ld  in  3  per-layer tile load strobe: [0]=fix, [1]=A, [2]=B.
- rom_d  in  32  ROM word, PIX_BITS planes x 8 pixels.
- col  in  ATTR_W  COL attribute for the tile being loaded.
- hflip  in  1  horizontal flip for the tile being loaded.
- za  in  3  layer A fine scroll.
- zb  in  3  layer B fine scroll.
- blank  in  1  force all pixel outputs to 0.
- clr_err  in  1  clear underrun flags.
- pix_fix / pix_a / pix_b  out  PIX_BITS each  pixel colour codes.
- attr_fix / attr_a / attr_b  out  ATTR_W each  attribute of the displayed pixel.
- opq  out  3  opaque flag per layer (pixel code != 0).
- px  out  3  pixel phase counter.
- underrun  out  3  sticky per-layer underrun flags.

Behaviour:
- Single clock domain: clk_24M. Reset is asynchronous and active-low (nRES); every register clears while nRES=0.
- Reset values: all outputs 0; px=0; all tile buffers hold transparent code 0 with attribute 0; underrun=0.
- Phase counter px:
  - Increments mod 8 on pix_ce.
  - The "boundary" is pix_ce while px==7.
- Per-layer three-stage buffer:
  - staging: written by ld, with valid flag stg_v.
  - front: next tile.
  - back: tile currently displayed.
  - Each stage holds 8 unpacked pixels plus its attribute.
- Unpack at load: pixel p, plane k = rom_d[k*8 + (7-p)]. If hflip=1, p is replaced by 7-p.
- ld[n] in any cycle: staging[n] <= unpacked data; stg_v[n] <= 1.
- At the boundary, for each layer:
  - back <= front.
  - front <= staging if stg_v, else all-zero pixels with attribute 0.
  - stg_v <= 0.
  - If stg_v was 0, underrun[n] <= 1.
- ld[n] coincident with the boundary:
  - Incoming data bypasses straight into front.
  - stg_v ends 0.
  - No underrun is flagged.
- Pixel select on each pix_ce, using the new px value:
  - Fine scroll z = 0 for fix, za for A, zb for B.
  - i = px + z, 4-bit, range 0..14.
  - i < 8: pixel = back[i], attribute = back attribute.
  - i >= 8: pixel = front[i-8], attribute = front attribute.
- za/zb are sampled on the same pix_ce; changing them mid-tile takes effect on the next pixel.
- Outputs are registered, 1 clk_24M latency after pix_ce. They hold between pix_ce pulses.
- blank=1 at pix_ce: pix_* = 0, attr_* = 0, opq = 0. Buffers and px continue advancing.
- opq[n] = |pix_n, registered together with the pixel.
- underrun: sticky. clr_err clears it in that cycle; a coincident new underrun wins (flag stays 1).
- Reset mid-line: immediate clear, px restarts at 0 after release; no partial state survives.

Decomposition:
- Shared package:
  - PLANE_W=8.
  - Layer index constants LAY_FIX=0, LAY_A=1, LAY_B=2.
  - Tile-row type: 8 x PIX_BITS pixels plus ATTR_W attribute.
  - Unpack function (planar -> pixel array, with hflip).
- One sub-module, tile_layer_pipe: staging/front/back, underrun, pixel select for one layer. Instantiated 3 times; fix instance has z tied to 0.
- Top holds px, blank and clr_err handling.

Test Plan:
- Reset: hold nRES=0 with pix_ce toggling -> all outputs 0, px=0; after release px steps 0..7.
- Unpack: ld[0] with rom_d=32'h000000FF each tile, hflip=0, z=0 -> after two boundaries pix_fix = 1 on all 8 pixels, opq[0]=1. With rom_d=32'h00000080 -> pix_fix = 1 only at px=0. With hflip=1 -> only at px=7.
- Fine scroll: layer A tiles alternate T0 (all pixels 3) and T1 (all pixels 5), za=3 -> each 8-pixel span shows five 3s then three 5s; attr_a changes at the same pixel.
- Coincident load at boundary: ld[1] exactly on px==7 pix_ce -> data appears in front, underrun[1] stays 0, stg_v=0.
- Underrun: omit ld[2] for one tile period -> underrun[2]=1; that tile displays pix_b=0, opq[2]=0. clr_err same cycle as a new underrun -> flag stays 1.
- Blank: blank=1 for 4 pixels mid-tile -> outputs 0 for those pixels; px and buffers unaffected; the following pixels continue at the correct index.
